parity_serializer: RTL and testbench

Upstream feeder for the serial even-parity FSM. Accepts parallel data words over a valid/ready handshake and shifts them out one bit per clock on a serial line (`w`). Each word can be followed by its even-parity bit, so that every frame carries an even number of ones. Frames are emitted back-to-back with no idle gap while words keep arriving, so the downstream FSM sees a continuous bit stream.

---
 rtl/parity_serializer_pkg.sv | 15 +
 rtl/parity_serializer.sv | 135 +++++++++++++
 tb/tb_parity_serializer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/parity_serializer_pkg.sv
// Shared definitions for the parity serializer: state encoding and parity helper.
package parity_ser_pkg;

  localparam int MAX_W = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;

  // Even-parity bit: makes (popcount(data) + bit) even. Narrow words are zero-extended.
  function automatic logic even_parity(input logic [MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_serializer.sv
// Parallel-to-serial feeder that appends an optional even-parity bit per frame.
//
// state | meaning
// IDLE  | no frame on w; ready for a word
// DATA  | a data bit of the current frame is on w
// PAR   | the parity bit (last bit of the frame) is on w
//
// cnt_q counts the bits still to follow the one currently on w, so the
// current bit is the frame's last when cnt_q reaches zero. Outputs are all
// registered; in_ready depends only on state and rst, never on in_valid.
module parity_serializer
  import parity_ser_pkg::*;
#(
  parameter int DATA_W     = 3,
  parameter int MSB_FIRST  = 1,
  parameter int ADD_PARITY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              w,
  output logic              w_valid,
  output logic              w_first,
  output logic              w_last,
  output logic              busy
);

  localparam int F     = DATA_W + ADD_PARITY;
  localparam int CNT_W = (F > 1) ? $clog2(F) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(F - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              w_q, w_d;
  logic              w_valid_q, w_valid_d;
  logic              w_first_q, w_first_d;
  logic              w_last_q, w_last_d;

  logic              xfer;
  logic [MAX_W-1:0]  data_ext;

  // Handshake: ready when idle or when the bit on w closes the frame.
  always_comb begin
    in_ready = !rst && ((state_q == IDLE) || (cnt_q == '0));
    xfer     = in_valid && in_ready;
    data_ext = '0;
    data_ext[DATA_W-1:0] = in_data;
  end

  // Next-state logic: load a new word, step through data/parity bits, or drop to idle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    cnt_d     = cnt_q;
    w_d       = 1'b0;
    w_valid_d = 1'b0;
    w_first_d = 1'b0;
    w_last_d  = 1'b0;

    if (xfer) begin
      // First bit goes straight to w; shreg keeps only the bits still to send.
      state_d   = DATA;
      par_d     = even_parity(data_ext);
      cnt_d     = CNT_LOAD;
      w_valid_d = 1'b1;
      w_first_d = 1'b1;
      w_last_d  = (F == 1);
      if (MSB_FIRST != 0) begin
        w_d     = in_data[DATA_W-1];
        shreg_d = in_data << 1;
      end else begin
        w_d     = in_data[0];
        shreg_d = in_data >> 1;
      end
    end else if ((state_q != IDLE) && (cnt_q != '0)) begin
      cnt_d     = cnt_q - CNT_ONE;
      w_valid_d = 1'b1;
      w_last_d  = (cnt_q == CNT_ONE);
      if ((ADD_PARITY != 0) && (cnt_q == CNT_ONE)) begin
        state_d = PAR;
        w_d     = par_q;
      end else begin
        state_d = DATA;
        if (MSB_FIRST != 0) begin
          w_d     = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
        end else begin
          w_d     = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
      par_d   = 1'b0;
    end
  end

  // State and output registers with synchronous reset; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      cnt_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      w_first_q <= 1'b0;
      w_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      w_first_q <= w_first_d;
      w_last_q  <= w_last_d;
    end
  end

  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign w_first = w_first_q;
  assign w_last  = w_last_q;
  assign busy    = w_valid_q;

endmodule

// File: tb/tb_parity_serializer.sv
// Directed bench: default (MSB first, parity) instance u0 and LSB-first, no-parity instance u1.
module tb_parity_serializer;

  logic clk = 1'b0;
  logic rst;
  logic iv0, ir0, w0, wv0, wf0, wl0, b0;
  logic iv1, ir1, w1, wv1, wf1, wl1, b1;
  logic [2:0] id0, id1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_serializer #(.DATA_W(3), .MSB_FIRST(1), .ADD_PARITY(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .w(w0), .w_valid(wv0), .w_first(wf0), .w_last(wl0), .busy(b0));

  parity_serializer #(.DATA_W(3), .MSB_FIRST(0), .ADD_PARITY(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .w(w1), .w_valid(wv1), .w_first(wf1), .w_last(wl1), .busy(b1));

  typedef struct {
    logic [2:0] data;
    logic [3:0] bits;   // expected w in time order, leftmost first
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait (bounded) for ready, let it transfer, then scramble in_data.
  task automatic send(input int sel, input logic [2:0] d);
    int n = 0;
    if (sel == 0) begin iv0 = 1'b1; id0 = d; end
    else          begin iv1 = 1'b1; id1 = d; end
    while (((sel == 0) ? ir0 : ir1) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
    tick();
    if (sel == 0) begin iv0 = 1'b0; id0 = 3'($urandom); end
    else          begin iv1 = 1'b0; id1 = 3'($urandom); end
  endtask

  // Check n consecutive frame bits (frames of length flen), then leave on the following cycle.
  task automatic frame_check(input int sel, input logic [7:0] bits, input int n,
                             input int flen, input string tag);
    logic ow, ov, of, ol;
    int ones = 0;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin ow = w0; ov = wv0; of = wf0; ol = wl0; end
      else          begin ow = w1; ov = wv1; of = wf1; ol = wl1; end
      chk({tag, "_w"},     int'(ow), int'(bits[n-1-i]));
      chk({tag, "_valid"}, int'(ov), 1);
      chk({tag, "_first"}, int'(of), int'(i % flen == 0));
      chk({tag, "_last"},  int'(ol), int'(i % flen == flen - 1));
      if (ow === 1'b1) ones++;
      if (sel == 0 && (i % flen == flen - 1)) begin
        chk({tag, "_even_ones"}, ones % 2, 0);
        ones = 0;
      end
      tick();
    end
  endtask

  task automatic idle_check(input int sel, input string tag);
    chk({tag, "_idle_valid"}, int'((sel == 0) ? wv0 : wv1), 0);
    chk({tag, "_idle_w"},     int'((sel == 0) ? w0 : w1), 0);
    chk({tag, "_idle_busy"},  int'((sel == 0) ? b0 : b1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b101, 4'b1010};
    vecs[1] = '{3'b100, 4'b1001};
    vecs[2] = '{3'b111, 4'b1111};
    vecs[3] = '{3'b000, 4'b0000};
    vecs[4] = '{3'b011, 4'b0110};
    vecs[5] = '{3'b110, 4'b1100};
    vecs[6] = '{3'b001, 4'b0011};
    vecs[7] = '{3'b010, 4'b0101};

    rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; id0 = 3'b000; id1 = 3'b000;

    // Reset for 2 cycles, then 10 idle cycles.
    tick();
    tick();
    chk("rst_ready0", int'(ir0), 0);
    chk("rst_ready1", int'(ir1), 0);
    chk("rst_valid0", int'(wv0), 0);
    chk("rst_w0", int'(w0), 0);
    chk("rst_first0", int'(wf0), 0);
    chk("rst_last0", int'(wl0), 0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("idle_ready0", int'(ir0), 1);
      chk("idle_ready1", int'(ir1), 1);
      idle_check(0, "idle0");
      idle_check(1, "idle1");
      tick();
    end

    // Table of single words through the default instance.
    for (int k = 0; k < 8; k++) begin
      send(0, vecs[k].data);
      frame_check(0, {4'b0000, vecs[k].bits}, 4, 4, "vec");
      idle_check(0, "vec");
      tick();
    end

    // Back-to-back 111 then 000 with in_valid held high.
    iv0 = 1'b1; id0 = 3'b111;
    tick();
    id0 = 3'b000;
    begin
      logic [7:0] exp_b2b = 8'b1111_0000;
      for (int i = 0; i < 8; i++) begin
        chk("b2b_w", int'(w0), int'(exp_b2b[7-i]));
        chk("b2b_valid", int'(wv0), 1);
        chk("b2b_ready", int'(ir0), int'(i == 3 || i == 7));
        if (i == 7) iv0 = 1'b0;
        tick();
      end
    end
    idle_check(0, "b2b");

    // LSB first, no parity: 110 -> 0,1,1.
    send(1, 3'b110);
    frame_check(1, 8'b0000_0011, 3, 3, "lsb");
    idle_check(1, "lsb");

    // LSB back-to-back without parity stays in DATA: 110 then 001 -> 0,1,1,1,0,0.
    iv1 = 1'b1; id1 = 3'b110;
    tick();
    id1 = 3'b001;
    begin
      logic [5:0] exp_l = 6'b011_100;
      for (int i = 0; i < 6; i++) begin
        chk("lsb_b2b_w", int'(w1), int'(exp_l[5-i]));
        chk("lsb_b2b_ready", int'(ir1), int'(i == 2 || i == 5));
        chk("lsb_b2b_first", int'(wf1), int'(i == 0 || i == 3));
        if (i == 5) iv1 = 1'b0;
        tick();
      end
    end
    idle_check(1, "lsb_b2b");

    // Reset mid-frame: 011 sends 0,1 then reset.
    send(0, 3'b011);
    chk("mid_bit1", int'(w0), 0);
    tick();
    chk("mid_bit2", int'(w0), 1);
    rst = 1'b1;
    #1;
    chk("mid_ready_in_rst", int'(ir0), 0);
    tick();
    idle_check(0, "mid_rst");
    rst = 1'b0;
    #1;
    chk("mid_ready_after", int'(ir0), 1);
    tick();
    idle_check(0, "mid_after");
    send(0, 3'b001);
    frame_check(0, 8'b0000_0011, 4, 4, "post_rst");
    idle_check(0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
